// File: rtl/div_sequencer_pkg.sv
// Shared ALU opcode definitions and helpers for classifying the divide/remainder ops.
package div_sequencer_pkg;

    typedef logic [5:0] aluop_t;

    localparam aluop_t OPADD  = 6'd0;
    localparam aluop_t OPDIV  = 6'd12;
    localparam aluop_t OPDIVU = 6'd13;
    localparam aluop_t OPREM  = 6'd14;
    localparam aluop_t OPREMU = 6'd15;

    localparam logic [31:0] ZERO = 32'd0;

    function automatic logic is_div_op(input aluop_t op);
        return (op == OPDIV) || (op == OPDIVU) || (op == OPREM) || (op == OPREMU);
    endfunction

    function automatic logic is_signed_op(input aluop_t op);
        return (op == OPDIV) || (op == OPREM);
    endfunction

    function automatic logic is_quot_op(input aluop_t op);
        return (op == OPDIV) || (op == OPDIVU);
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational radix-2 restoring division step on a {rem, quot} register pair.
// Zero latency; the caller owns all sequencing.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quot_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quot_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // The shifted partial remainder needs one extra bit before the trial subtract.
    assign shifted = {rem_i, quot_i[WIDTH-1]};
    assign diff    = shifted - {1'b0, divisor_i};

    always_comb begin
        if (!diff[WIDTH]) begin
            rem_o  = diff[WIDTH-1:0];
            quot_o = {quot_i[WIDTH-2:0], 1'b1};
        end else begin
            rem_o  = shifted[WIDTH-1:0];
            quot_o = {quot_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU/REM/REMU sequencer: WIDTH+3 cycles to oDone, 2 for div-by-zero/overflow.
// oBusy stalls execute until the one-cycle oDone pulse; iFlush aborts without oDone.
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iStart,
    input  logic [5:0]       iControlSignal,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    input  logic             iFlush,
    output logic             oBusy,
    output logic             oDone,
    output logic [WIDTH-1:0] oResult
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_ITER  = 3'd2,
        S_FIX   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    aluop_t           op_q, op_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] step_rem, step_quot;
    logic             sgn, want_quot, a_neg, b_neg, div_zero, ovf;
    logic [WIDTH-1:0] a_abs, b_abs, q_fix, r_fix;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .quot_i    (quot_q),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .quot_o    (step_quot)
    );

    // Raw operands sit in quot_q/dvs_q from acceptance until SETUP rewrites them.
    assign sgn       = is_signed_op(op_q);
    assign want_quot = is_quot_op(op_q);
    assign a_neg     = sgn & quot_q[WIDTH-1];
    assign b_neg     = sgn & dvs_q[WIDTH-1];
    assign a_abs     = a_neg ? -quot_q : quot_q;
    assign b_abs     = b_neg ? -dvs_q : dvs_q;
    assign div_zero  = (dvs_q == '0);
    assign ovf       = sgn && (quot_q == MIN_NEG) && (dvs_q == '1);
    assign q_fix     = negq_q ? -quot_q : quot_q;
    assign r_fix     = negr_q ? -rem_q : rem_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quot_d   = quot_q;
        dvs_d    = dvs_q;
        op_d     = op_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (iStart && !iFlush && is_div_op(iControlSignal)) begin
                    state_d = S_SETUP;
                    quot_d  = iA;
                    dvs_d   = iB;
                    op_d    = iControlSignal;
                end
            end
            S_SETUP: begin
                if (div_zero) begin
                    result_d = want_quot ? '1 : quot_q;
                    state_d  = S_DONE;
                end else if (ovf) begin
                    result_d = want_quot ? MIN_NEG : '0;
                    state_d  = S_DONE;
                end else begin
                    quot_d  = a_abs;
                    dvs_d   = b_abs;
                    rem_d   = '0;
                    negq_d  = a_neg ^ b_neg;
                    negr_d  = a_neg;
                    cnt_d   = CW'(WIDTH - 1);
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                rem_d  = step_rem;
                quot_d = step_quot;
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_FIX: begin
                result_d = want_quot ? q_fix : r_fix;
                state_d  = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (iFlush && state_q != S_IDLE) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end

        busy_d = (state_d == S_SETUP) || (state_d == S_ITER) || (state_d == S_FIX);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quot_q   <= '0;
            dvs_q    <= '0;
            op_q     <= OPADD;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quot_q   <= quot_d;
            dvs_q    <= dvs_d;
            op_q     <= op_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign oBusy   = busy_q;
    assign oDone   = done_q;
    assign oResult = result_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed spec cases plus randomized ops against an arithmetic model.
module tb_div_sequencer;
    import div_sequencer_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic [5:0]   op = OPADD;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done;
    logic [W-1:0] result;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    div_sequencer #(.WIDTH(W)) dut (
        .iCLK           (clk),
        .iRST           (rst_n),
        .iStart         (start),
        .iControlSignal (op),
        .iA             (a),
        .iB             (b),
        .iFlush         (flush),
        .oBusy          (busy),
        .oDone          (done),
        .oResult        (result)
    );

    function automatic logic [31:0] ref_result(input logic [5:0] o, input logic [31:0] x, input logic [31:0] y);
        bit is_rem;
        bit sgn;
        int sx, sy;
        is_rem = (o == OPREM) || (o == OPREMU);
        sgn    = (o == OPDIV) || (o == OPREM);
        if (y == 0) return is_rem ? x : 32'hFFFF_FFFF;
        if (sgn && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return is_rem ? 32'h0 : 32'h8000_0000;
        if (sgn) begin
            sx = x;
            sy = y;
            return is_rem ? 32'(sx % sy) : 32'(sx / sy);
        end
        return is_rem ? (x % y) : (x / y);
    endfunction

    function automatic int ref_latency(input logic [5:0] o, input logic [31:0] x, input logic [31:0] y);
        bit sgn;
        sgn = (o == OPDIV) || (o == OPREM);
        if (y == 0) return 2;
        if (sgn && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 2;
        return W + 3;
    endfunction

    // Drives one start, then watches each cycle (at the falling edge) until oDone.
    // intrude>0 raises a second start with junk operands during that busy cycle.
    task automatic run_op(input logic [5:0] o, input logic [31:0] x, input logic [31:0] y,
                          input int intrude, output int lat, output logic [31:0] res, output bit busy_ok);
        int cyc;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; op = OPADD; a = $urandom; b = $urandom;
        cyc = 1; busy_ok = 1'b1; lat = -1; res = result;
        while (cyc < 100) begin
            if (done) begin
                lat = cyc;
                res = result;
                if (busy) busy_ok = 1'b0;
                break;
            end
            if (!busy) busy_ok = 1'b0;
            if (cyc == intrude) begin
                start = 1'b1; op = OPREMU; a = $urandom; b = $urandom | 32'd1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (result !== '0) begin bad++; $display("FAIL reset_result got=%h want=0", result); end
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [5:0]  o;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    task automatic test_directed();
        vec_t vt[9];
        int lat;
        logic [31:0] res;
        bit bok;
        vt[0] = '{OPDIV,  32'd100,         32'd7,           32'd14,          35};
        vt[1] = '{OPREM,  32'd100,         32'd7,           32'd2,           35};
        vt[2] = '{OPDIV,  32'hFFFF_FFF9,   32'd2,           32'hFFFF_FFFD,   35};
        vt[3] = '{OPREM,  32'hFFFF_FFF9,   32'd2,           32'hFFFF_FFFF,   35};
        vt[4] = '{OPDIVU, 32'hFFFF_FFFF,   32'd1,           32'hFFFF_FFFF,   35};
        vt[5] = '{OPDIV,  32'd5,           32'd0,           32'hFFFF_FFFF,   2};
        vt[6] = '{OPREMU, 32'd5,           32'd0,           32'd5,           2};
        vt[7] = '{OPDIV,  32'h8000_0000,   32'hFFFF_FFFF,   32'h8000_0000,   2};
        vt[8] = '{OPREM,  32'h8000_0000,   32'hFFFF_FFFF,   32'd0,           2};
        foreach (vt[i]) begin
            run_op(vt[i].o, vt[i].x, vt[i].y, 0, lat, res, bok);
            total++; if (res !== vt[i].exp) begin bad++; $display("FAIL dir%0d_result got=%h want=%h", i, res, vt[i].exp); end
            total++; if (lat !== vt[i].lat) begin bad++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, lat, vt[i].lat); end
            total++; if (bok !== 1'b1) begin bad++; $display("FAIL dir%0d_busy got=%b want=1", i, bok); end
        end
    endtask

    task automatic test_random();
        logic [5:0] ops[4];
        logic [5:0] o;
        logic [31:0] x, y, res;
        int lat, sel;
        bit bok;
        ops[0] = OPDIV; ops[1] = OPDIVU; ops[2] = OPREM; ops[3] = OPREMU;
        for (int n = 0; n < 40; n++) begin
            o = ops[$urandom_range(0, 3)];
            sel = $urandom_range(0, 5);
            x = $urandom;
            y = $urandom;
            case (sel)
                0: y = 32'd0;
                1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
                2: begin x = $urandom_range(0, 1000); y = $urandom_range(1, 50); end
                3: y = $urandom_range(1, 300) * (($urandom & 1) ? 32'hFFFF_FFFF : 32'd1);
                default: ;
            endcase
            run_op(o, x, y, 0, lat, res, bok);
            total++; if (res !== ref_result(o, x, y)) begin bad++; $display("FAIL rand%0d_result op=%0d a=%h b=%h got=%h want=%h", n, o, x, y, res, ref_result(o, x, y)); end
            total++; if (lat !== ref_latency(o, x, y)) begin bad++; $display("FAIL rand%0d_latency got=%0d want=%0d", n, lat, ref_latency(o, x, y)); end
            total++; if (bok !== 1'b1) begin bad++; $display("FAIL rand%0d_busy got=%b want=1", n, bok); end
        end
    endtask

    task automatic test_flush();
        int lat;
        logic [31:0] res;
        bit bok;
        run_op(OPDIV, 32'd1000, 32'd10, 0, lat, res, bok);
        @(negedge clk);
        start = 1'b1; op = OPDIV; a = 32'd77; b = 32'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < 10; c++) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL flush_done got=%b want=0", done); end
        total++; if (result !== 32'd100) begin bad++; $display("FAIL flush_result_hold got=%h want=%h", result, 32'd100); end
        run_op(OPREMU, 32'd77, 32'd5, 0, lat, res, bok);
        total++; if (res !== 32'd2) begin bad++; $display("FAIL flush_restart_result got=%h want=2", res); end
        total++; if (lat !== 35) begin bad++; $display("FAIL flush_restart_latency got=%0d want=35", lat); end
    endtask

    task automatic test_ignore_busy();
        int lat;
        logic [31:0] res;
        bit bok;
        run_op(OPDIVU, 32'd12345, 32'd11, 5, lat, res, bok);
        total++; if (res !== 32'd1122) begin bad++; $display("FAIL busy_start_result got=%h want=%h", res, 32'd1122); end
        total++; if (lat !== 35) begin bad++; $display("FAIL busy_start_latency got=%0d want=35", lat); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL busy_start_noqueue cyc=%0d busy=%b done=%b want=0/0", c, busy, done); end
        end
    endtask

    task automatic test_opadd();
        @(negedge clk);
        start = 1'b1; op = OPADD; a = 32'd9; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL opadd_idle cyc=%0d busy=%b done=%b want=0/0", c, busy, done); end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [31:0] res;
        bit bok;
        run_op(OPDIV, 32'd500, 32'd4, 0, lat, res, bok);
        @(negedge clk);
        start = 1'b1; op = OPDIV; a = 32'd999; b = 32'd9;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < 20; c++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rstmid_done got=%b want=0", done); end
        total++; if (result !== '0) begin bad++; $display("FAIL rstmid_result got=%h want=0", result); end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(OPREM, 32'hFFFF_FF9C, 32'd7, 0, lat, res, bok);
        total++; if (res !== ref_result(OPREM, 32'hFFFF_FF9C, 32'd7)) begin bad++; $display("FAIL rstmid_after_result got=%h want=%h", res, ref_result(OPREM, 32'hFFFF_FF9C, 32'd7)); end
        total++; if (lat !== 35) begin bad++; $display("FAIL rstmid_after_latency got=%0d want=35", lat); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_ignore_busy();
        test_opadd();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Multi-cycle sequencer for the M-extension divide/remainder operations (DIV, DIVU, REM, REMU), replacing the single-cycle combinational divide path in the execute stage. It captures operands on a start pulse and runs a radix-2 restoring division over WIDTH iterations. It resolves RISC-V special cases and holds a busy signal that the pipeline uses to stall execute until a one-cycle done pulse.

## Interface
- WIDTH, 32, operand and result width in bits.
- iCLK  in  1  core clock; all state updates on the rising edge.
- iRST  in  1  asynchronous, active-low reset.
- iStart  in  1  request pulse; sampled only in IDLE.
- iControlSignal  in  6  ALU operation code; only OPDIV/OPDIVU/OPREM/OPREMU start the sequencer.
- iA  in  WIDTH  dividend, captured at accepted start.
- iB  in  WIDTH  divisor, captured at accepted start.
- iFlush  in  1  abort the current operation (pipeline flush).
- oBusy  out  WIDTH-independent 1  high from the cycle after acceptance until oDone.
- oDone  out  1  one-cycle pulse; oResult is valid in this cycle.
- oResult  out  WIDTH  quotient or remainder per captured opcode.

## Operation
- States: IDLE, SETUP, ITER, FIX, DONE.
- Start acceptance: IDLE with iStart=1 and a divide opcode latches iA, iB and the opcode, then goes to SETUP. Any other opcode leaves the sequencer in IDLE.
- Start is ignored outside IDLE. No queueing.
- SETUP:
  - Signed ops: compute absolute values, negQ = sign(A)^sign(B), negR = sign(A).
  - Divide by zero (B=0) goes straight to DONE. Quotient = all ones; remainder = A.
  - Signed overflow (A=0x80000000, B=0xFFFFFFFF) goes straight to DONE. Quotient = 0x80000000; remainder = 0.
  - Otherwise go to ITER with the counter at WIDTH-1.
- ITER: one restoring step per cycle.
  - Shift the {rem, quot} register pair left by one.
  - Trial-subtract the divisor; on non-negative, commit the difference and set quot[0]=1.
  - Decrement the counter; at 0, go to FIX.
- FIX: conditional two's-complement negation.
  - Negate the quotient if negQ.
  - Negate the remainder if negR.
  - Unsigned ops pass through unchanged.
- DONE: assert oDone; drive oResult (quotient for DIV/DIVU, remainder for REM/REMU); return to IDLE next cycle.
- oResult holds its last value until the next DONE.
- iFlush: in any non-IDLE state, go to IDLE on the next edge. oBusy drops, no oDone, oResult unchanged. iFlush has priority over iStart in the same cycle.
- Reset mid-operation: immediate return to IDLE; all outputs take their reset values.
- Reset values: oBusy=0, oDone=0, oResult=0, state=IDLE, counter=0.

## Timing
- Accept edge = cycle 0.
- Normal operation:
  - SETUP in cycle 1.
  - ITER in cycles 2..WIDTH+1.
  - FIX in cycle WIDTH+2.
  - oDone in cycle WIDTH+3 (35 for WIDTH=32).
- Special cases: oDone in cycle 2.
- oBusy is high in cycles 1 through the cycle before oDone.
- oBusy is low during the oDone cycle, so the pipeline releases its stall while it captures oResult.
- A new start is accepted in the cycle after oDone, giving a back-to-back throughput of WIDTH+4 cycles.
- No combinational path from iA/iB to any output. All outputs are registered.

## Structure
- The shared ALU-op package supplies OPDIV, OPDIVU, OPREM and OPREMU. It also supplies ZERO.
- The state encoding lives as localparams inside this block.
- One natural sub-module: div_step, a combinational single restoring step.
  - Inputs: rem, quot, divisor.
  - Outputs: next rem, next quot.
  - It can be unit-tested in isolation.

## Test plan
- DIV 100/7: oDone at cycle 35, oResult=14; REM 100%7 gives 2 at the same latency.
- DIV -7/2 gives 0xFFFFFFFD (-3); REM -7%2 gives 0xFFFFFFFF (-1); DIVU 0xFFFFFFFF/1 gives 0xFFFFFFFF.
- Divide by zero:
  - DIV 5/0 gives 0xFFFFFFFF at cycle 2.
  - REMU 5/0 gives 5 at cycle 2.
- Overflow:
  - DIV 0x80000000/0xFFFFFFFF gives 0x80000000 at cycle 2.
  - REM of the same operands gives 0.
- iFlush at cycle 10 of a DIV: IDLE at cycle 11, oBusy=0, no oDone, oResult keeps its prior value. A start at cycle 12 completes normally.
- Reset and start filtering:
  - iRST low at cycle 20: outputs read 0 immediately.
  - iStart while busy is ignored.
  - iStart with OPADD never raises oBusy.
